level_tick_timer: RTL

- Parametrised programmable interval timer that replaces the fixed-count timers and the level/switch-selected clock dividers.
- Produces a single-cycle Tick enable, never a derived clock, so downstream logic stays on Clk.
- Period is selected from a level index using an arithmetic table.
- Supports periodic and one-shot modes, pause via En, and explicit Start/Stop control with a Done flag.
- Drives ball/paddle speed stepping and round-delay timing in the game datapath.

---
 rtl/level_tick_timer.sv | 112 +++++++++++
 1 files changed

// File: rtl/level_tick_timer.sv
// rtl/level_tick_timer.sv - level-indexed programmable interval timer with single-cycle Tick enable
module level_tick_timer #(
    parameter int CNT_W       = 32,
    parameter int LEVEL_W     = 4,
    parameter int NUM_LEVELS  = 11,
    parameter int BASE_PERIOD = 50000000,
    parameter int STEP        = 5000000
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Mode,
    input  logic [LEVEL_W-1:0] Level,
    output logic               Tick,
    output logic               Toggle,
    output logic               Busy,
    output logic               Done,
    output logic [CNT_W-1:0]   Count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] base_c = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] step_c = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] last_c = CNT_W'(NUM_LEVELS - 1);

    // The shortest period must still leave room for a non-terminal count.
    if (BASE_PERIOD - STEP * (NUM_LEVELS - 2) < 2) begin : g_bad_period
        $error("level_tick_timer: shortest period is below 2 cycles");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] preg, preg_n;
    logic [CNT_W-1:0] lvl_sel, period;
    logic             mode_q, mode_n;
    logic             tick_q, tick_n;
    logic             toggle_q, toggle_n;

    always_comb begin
        lvl_sel = CNT_W'(Level);
        if (lvl_sel == '0) begin
            lvl_sel = CNT_W'(1);
        end else if (lvl_sel > last_c) begin
            lvl_sel = last_c;
        end
        period = base_c - step_c * (lvl_sel - CNT_W'(1));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            count_q  <= '0;
            preg     <= base_c;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            state    <= state_n;
            count_q  <= count_n;
            preg     <= preg_n;
            mode_q   <= mode_n;
            tick_q   <= tick_n;
            toggle_q <= toggle_n;
        end
    end

    // Stop beats Start beats terminal count; a restart silently drops the truncated period.
    always_comb begin
        state_n  = state;
        count_n  = count_q;
        preg_n   = preg;
        mode_n   = mode_q;
        tick_n   = 1'b0;
        toggle_n = toggle_q;
        if (Stop) begin
            state_n = ST_IDLE;
            count_n = '0;
        end else if (Start) begin
            state_n = ST_RUN;
            count_n = '0;
            preg_n  = period;
            mode_n  = Mode;
        end else if (state == ST_RUN && En) begin
            if (count_q == preg - CNT_W'(1)) begin
                count_n  = '0;
                tick_n   = 1'b1;
                toggle_n = ~toggle_q;
                if (mode_q) begin
                    state_n = ST_DONE;
                end else begin
                    preg_n = period;
                end
            end else begin
                count_n = count_q + CNT_W'(1);
            end
        end
    end

    assign Tick   = tick_q;
    assign Toggle = toggle_q;
    assign Busy   = (state == ST_RUN);
    assign Done   = (state == ST_DONE);
    assign Count  = count_q;

endmodule
